// File: rtl/data_mem_unit.sv
`default_nettype none
// data_mem_unit: serialised load/store memory stage with configurable read latency and fault reporting.
// Revision 1.0 - initial release.
module data_mem_unit #(
  parameter int XLEN         = 64,
  parameter int DEPTH_WORDS  = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [4:0]      req_rd,
  input  logic            req_regwrite,
  input  logic            req_memtoreg,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic [1:0]      resp_fault,
  output logic [4:0]      resp_rd,
  output logic            resp_regwrite,
  output logic            resp_memtoreg
);

  localparam int BYTES  = XLEN / 8;
  localparam int LANE_W = $clog2(BYTES);
  localparam int IDX_W  = $clog2(DEPTH_WORDS);
  localparam int BIT_W  = $clog2(XLEN);
  localparam logic [XLEN-1:0] MEM_BYTES = XLEN'(DEPTH_WORDS * BYTES);
  localparam logic [2:0]      CNT_INIT  = 3'(READ_LATENCY - 1);

  localparam logic [1:0] FAULT_NONE  = 2'b00;
  localparam logic [1:0] FAULT_ALIGN = 2'b01;
  localparam logic [1:0] FAULT_RANGE = 2'b10;
  localparam logic [1:0] FAULT_SIZE  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  logic [2:0]        cnt;
  logic [XLEN-1:0]   mem [DEPTH_WORDS];

  logic              accept;
  logic              misaligned;
  logic [1:0]        fault;
  logic [IDX_W-1:0]  idx;
  logic [LANE_W-1:0] lane;
  logic [BYTES-1:0]  size_mask;
  logic [BYTES-1:0]  be;
  logic [XLEN-1:0]   wdata_sh;
  logic [XLEN-1:0]   word_sh;
  logic [XLEN-1:0]   load_ext;
  logic [BIT_W-1:0]  msb;
  logic              sign;

  assign req_ready  = (state == IDLE) && !reset;
  assign resp_valid = (state == RESP);
  assign accept     = req_valid && req_ready;
  assign idx        = req_addr[IDX_W+LANE_W-1:LANE_W];
  assign lane       = req_addr[LANE_W-1:0];
  assign wdata_sh   = req_wdata << {lane, 3'b000};
  assign be         = size_mask << lane;

  always_comb begin
    misaligned = 1'b0;
    size_mask  = '0;
    msb        = '0;
    case (req_size)
      2'd0: begin
        misaligned = 1'b0;
        size_mask  = BYTES'(8'h01);
        msb        = BIT_W'(7);
      end
      2'd1: begin
        misaligned = req_addr[0];
        size_mask  = BYTES'(8'h03);
        msb        = BIT_W'(15);
      end
      2'd2: begin
        misaligned = |req_addr[1:0];
        size_mask  = BYTES'(8'h0F);
        msb        = BIT_W'(31);
      end
      default: begin
        misaligned = |req_addr[2:0];
        size_mask  = BYTES'(8'hFF);
        msb        = BIT_W'(XLEN - 1);
      end
    endcase
  end

  // Fault priority: illegal size, then alignment, then range.
  always_comb begin
    fault = FAULT_NONE;
    if ((XLEN == 32) && (req_size == 2'd3))
      fault = FAULT_SIZE;
    else if (misaligned)
      fault = FAULT_ALIGN;
    else if (req_addr >= MEM_BYTES)
      fault = FAULT_RANGE;
  end

  always_comb begin
    word_sh  = mem[idx] >> {lane, 3'b000};
    sign     = !req_unsigned && word_sh[msb];
    load_ext = '0;
    for (int i = 0; i < XLEN; i++)
      load_ext[i] = (i <= int'(msb)) ? word_sh[i] : sign;
  end

  always_ff @(posedge clk) begin
    if (accept && req_we && (fault == FAULT_NONE)) begin
      for (int b = 0; b < BYTES; b++)
        if (be[b])
          mem[idx][b*8 +: 8] <= wdata_sh[b*8 +: 8];
    end
  end

  // The counter reaching zero and the move to RESP share one edge,
  // so the response appears READ_LATENCY-1 edges after acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      resp_rdata    <= '0;
      resp_fault    <= FAULT_NONE;
      resp_rd       <= '0;
      resp_regwrite <= 1'b0;
      resp_memtoreg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            resp_rdata    <= (req_we || (fault != FAULT_NONE)) ? '0 : load_ext;
            resp_fault    <= fault;
            resp_rd       <= req_rd;
            resp_regwrite <= req_regwrite && (fault == FAULT_NONE);
            resp_memtoreg <= req_memtoreg;
            if (READ_LATENCY == 1) begin
              state <= RESP;
              cnt   <= '0;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt <= 3'd1) begin
            state <= RESP;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP: begin
          if (resp_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_unit.sv
`default_nettype none
// tb_data_mem_unit: directed checks on three instances (64-bit/latency 1, 64-bit/latency 3, 32-bit/latency 1).
// Revision 1.0 - initial release.
module tb_data_mem_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  vld;
  logic [2:0]  rrdy;
  logic        req_we;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [4:0]  req_rd;
  logic        req_regwrite;
  logic        req_memtoreg;

  logic        ready_a, valid_a, rw_a, mtr_a;
  logic [63:0] rdata_a;
  logic [1:0]  fault_a;
  logic [4:0]  rd_a;
  logic        ready_b, valid_b, rw_b, mtr_b;
  logic [63:0] rdata_b;
  logic [1:0]  fault_b;
  logic [4:0]  rd_b;
  logic        ready_c, valid_c, rw_c, mtr_c;
  logic [31:0] rdata_c;
  logic [1:0]  fault_c;
  logic [4:0]  rd_c;

  int          cur;
  logic        obs_ready, obs_valid, obs_rw, obs_mtr;
  logic [63:0] obs_rdata;
  logic [1:0]  obs_fault;
  logic [4:0]  obs_rd;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_mem_unit #(.XLEN(64), .DEPTH_WORDS(1024), .READ_LATENCY(1)) dut_a (
    .clk(clk), .reset(reset), .req_valid(vld[0]), .req_ready(ready_a),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_rd(req_rd), .req_regwrite(req_regwrite),
    .req_memtoreg(req_memtoreg), .resp_valid(valid_a), .resp_ready(rrdy[0]),
    .resp_rdata(rdata_a), .resp_fault(fault_a), .resp_rd(rd_a),
    .resp_regwrite(rw_a), .resp_memtoreg(mtr_a)
  );

  data_mem_unit #(.XLEN(64), .DEPTH_WORDS(1024), .READ_LATENCY(3)) dut_b (
    .clk(clk), .reset(reset), .req_valid(vld[1]), .req_ready(ready_b),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_rd(req_rd), .req_regwrite(req_regwrite),
    .req_memtoreg(req_memtoreg), .resp_valid(valid_b), .resp_ready(rrdy[1]),
    .resp_rdata(rdata_b), .resp_fault(fault_b), .resp_rd(rd_b),
    .resp_regwrite(rw_b), .resp_memtoreg(mtr_b)
  );

  data_mem_unit #(.XLEN(32), .DEPTH_WORDS(1024), .READ_LATENCY(1)) dut_c (
    .clk(clk), .reset(reset), .req_valid(vld[2]), .req_ready(ready_c),
    .req_we(req_we), .req_addr(req_addr[31:0]), .req_wdata(req_wdata[31:0]), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_rd(req_rd), .req_regwrite(req_regwrite),
    .req_memtoreg(req_memtoreg), .resp_valid(valid_c), .resp_ready(rrdy[2]),
    .resp_rdata(rdata_c), .resp_fault(fault_c), .resp_rd(rd_c),
    .resp_regwrite(rw_c), .resp_memtoreg(mtr_c)
  );

  always_comb begin
    obs_ready = ready_a; obs_valid = valid_a; obs_rdata = rdata_a; obs_fault = fault_a;
    obs_rd = rd_a; obs_rw = rw_a; obs_mtr = mtr_a;
    case (cur)
      1: begin
        obs_ready = ready_b; obs_valid = valid_b; obs_rdata = rdata_b; obs_fault = fault_b;
        obs_rd = rd_b; obs_rw = rw_b; obs_mtr = mtr_b;
      end
      2: begin
        obs_ready = ready_c; obs_valid = valid_c; obs_rdata = {32'h0, rdata_c}; obs_fault = fault_c;
        obs_rd = rd_c; obs_rw = rw_c; obs_mtr = mtr_c;
      end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [1:0] size, input logic uns, input logic [4:0] rd);
    req_we       = we;
    req_addr     = addr;
    req_wdata    = wdata;
    req_size     = size;
    req_unsigned = uns;
    req_rd       = rd;
    req_regwrite = ~we;
    req_memtoreg = ~we;
  endtask

  // Called just after a falling edge; returns just after a falling edge with the unit idle again.
  task automatic op(input string tag, input int sel, input logic we, input logic [63:0] addr,
                    input logic [63:0] wdata, input logic [1:0] size, input logic uns,
                    input logic [4:0] rd, input logic [63:0] exp_rdata,
                    input logic [1:0] exp_fault, input int exp_lat);
    int lat;
    cur = sel;
    set_req(we, addr, wdata, size, uns, rd);
    rrdy[sel] = 1'b1;
    vld[sel]  = 1'b1;
    #1;
    chk({tag, "_req_ready"}, 64'(obs_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    vld[sel] = 1'b0;
    lat = 1;
    while (!obs_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_rdata"}, obs_rdata, exp_rdata);
    chk({tag, "_fault"}, 64'(obs_fault), 64'(exp_fault));
    chk({tag, "_regwrite"}, 64'(obs_rw), 64'(!we && (exp_fault == 2'b00)));
    chk({tag, "_rd"}, 64'(obs_rd), 64'(rd));
    chk({tag, "_memtoreg"}, 64'(obs_mtr), 64'(!we));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic spurious;
    reset = 1'b1;
    vld   = 3'b000;
    rrdy  = 3'b111;
    cur   = 0;
    set_req(1'b0, 64'h0, 64'h0, 2'd0, 1'b0, 5'd0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_resp_valid", 64'(valid_a), 64'd0);
    chk("rst_resp_rdata", rdata_a, 64'd0);
    chk("rst_resp_fault", 64'(fault_a), 64'd0);
    chk("rst_resp_rd", 64'(rd_a), 64'd0);
    chk("rst_resp_regwrite", 64'(rw_a), 64'd0);
    chk("rst_resp_memtoreg", 64'(mtr_a), 64'd0);
    chk("rst_req_ready_held", 64'(ready_a), 64'd0);
    reset = 1'b0;
    #1;
    chk("rst_req_ready_released", 64'(ready_a), 64'd1);
    @(negedge clk);

    // 64-bit, latency 1
    op("a_st_d10", 0, 1, 64'h10, 64'h1122334455667788, 2'd3, 0, 5'd1, 64'h0, 2'b00, 1);
    op("a_ld_d10", 0, 0, 64'h10, 64'h0, 2'd3, 0, 5'd2, 64'h1122334455667788, 2'b00, 1);
    op("a_st_b13", 0, 1, 64'h13, 64'hDEADBEEFCAFE1280, 2'd0, 0, 5'd3, 64'h0, 2'b00, 1);
    op("a_ld_bs13", 0, 0, 64'h13, 64'h0, 2'd0, 0, 5'd4, 64'hFFFFFFFFFFFFFF80, 2'b00, 1);
    op("a_ld_bu13", 0, 0, 64'h13, 64'h0, 2'd0, 1, 5'd5, 64'h0000000000000080, 2'b00, 1);
    op("a_ld_d10b", 0, 0, 64'h10, 64'h0, 2'd3, 0, 5'd6, 64'h1122334480667788, 2'b00, 1);
    op("a_ld_h11", 0, 0, 64'h11, 64'h0, 2'd1, 0, 5'd7, 64'h0, 2'b01, 1);
    op("a_ld_ws10", 0, 0, 64'h10, 64'h0, 2'd2, 0, 5'd8, 64'hFFFFFFFF80667788, 2'b00, 1);
    op("a_ld_wu10", 0, 0, 64'h10, 64'h0, 2'd2, 1, 5'd9, 64'h0000000080667788, 2'b00, 1);
    op("a_ld_hu16", 0, 0, 64'h16, 64'h0, 2'd1, 1, 5'd10, 64'h0000000000001122, 2'b00, 1);
    op("a_ld_hs12", 0, 0, 64'h12, 64'h0, 2'd1, 0, 5'd11, 64'hFFFFFFFFFFFF8066, 2'b00, 1);
    op("a_st_d00", 0, 1, 64'h0, 64'h0123456789ABCDEF, 2'd3, 0, 5'd12, 64'h0, 2'b00, 1);
    op("a_st_w2000", 0, 1, 64'h2000, 64'hFFFFFFFFFFFFFFFF, 2'd2, 0, 5'd13, 64'h0, 2'b10, 1);
    op("a_ld_d00", 0, 0, 64'h0, 64'h0, 2'd3, 0, 5'd14, 64'h0123456789ABCDEF, 2'b00, 1);
    op("a_st_h03", 0, 1, 64'h3, 64'hFFFFFFFFFFFFFFFF, 2'd1, 0, 5'd15, 64'h0, 2'b01, 1);
    op("a_ld_d00b", 0, 0, 64'h0, 64'h0, 2'd3, 0, 5'd16, 64'h0123456789ABCDEF, 2'b00, 1);

    // 64-bit, latency 3: stalled response and ignored request
    op("b_st_d08", 1, 1, 64'h8, 64'hCAFEBABE12345678, 2'd3, 0, 5'd17, 64'h0, 2'b00, 3);
    cur     = 1;
    rrdy[1] = 1'b0;
    set_req(1'b0, 64'h8, 64'h0, 2'd3, 0, 5'd9);
    vld[1]  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    set_req(1'b1, 64'h8, 64'hFFFFFFFFFFFFFFFF, 2'd3, 0, 5'd20);
    chk("b_stall_valid_c1", 64'(valid_b), 64'd0);
    chk("b_stall_ready_c1", 64'(ready_b), 64'd0);
    @(negedge clk);
    chk("b_stall_valid_c2", 64'(valid_b), 64'd0);
    @(negedge clk);
    chk("b_stall_valid_c3", 64'(valid_b), 64'd1);
    chk("b_stall_rdata_c3", rdata_b, 64'hCAFEBABE12345678);
    chk("b_stall_ready_c3", 64'(ready_b), 64'd0);
    @(negedge clk);
    chk("b_stall_valid_c4", 64'(valid_b), 64'd1);
    chk("b_stall_rdata_c4", rdata_b, 64'hCAFEBABE12345678);
    chk("b_stall_rd_c4", 64'(rd_b), 64'd9);
    chk("b_stall_ready_c4", 64'(ready_b), 64'd0);
    @(negedge clk);
    chk("b_stall_valid_c5", 64'(valid_b), 64'd1);
    chk("b_stall_rdata_c5", rdata_b, 64'hCAFEBABE12345678);
    vld[1]  = 1'b0;
    rrdy[1] = 1'b1;
    @(negedge clk);
    chk("b_after_hs_valid", 64'(valid_b), 64'd0);
    chk("b_after_hs_ready", 64'(ready_b), 64'd1);
    op("b_ld_d08", 1, 0, 64'h8, 64'h0, 2'd3, 0, 5'd18, 64'hCAFEBABE12345678, 2'b00, 3);

    // Reset while waiting drops the response
    cur = 1;
    set_req(1'b0, 64'h8, 64'h0, 2'd3, 0, 5'd19);
    vld[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vld[1] = 1'b0;
    chk("b_wait_before_reset", 64'(valid_b), 64'd0);
    reset = 1'b1;
    #1;
    chk("b_reset_valid", 64'(valid_b), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("b_release_ready", 64'(ready_b), 64'd1);
    chk("b_release_valid", 64'(valid_b), 64'd0);
    spurious = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (valid_b) spurious = 1'b1;
    end
    chk("b_no_spurious_resp", 64'(spurious), 64'd0);

    // 32-bit, latency 1
    op("c_ld_d00", 2, 0, 64'h0, 64'h0, 2'd3, 0, 5'd21, 64'h0, 2'b11, 1);
    op("c_ld_d01", 2, 0, 64'h1, 64'h0, 2'd3, 0, 5'd22, 64'h0, 2'b11, 1);
    op("c_st_w04", 2, 1, 64'h4, 64'h0000000089ABCDEF, 2'd2, 0, 5'd23, 64'h0, 2'b00, 1);
    op("c_ld_hs06", 2, 0, 64'h6, 64'h0, 2'd1, 0, 5'd24, 64'h00000000FFFF89AB, 2'b00, 1);
    op("c_ld_w04", 2, 0, 64'h4, 64'h0, 2'd2, 1, 5'd25, 64'h0000000089ABCDEF, 2'b00, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_mem_unit.md
# data_mem_unit

Parametrised data-memory stage for the sequential RISC-V core, placed between execute and writeback. It serves loads and stores of byte, half, word and doubleword size, with sign or zero extension of load data. Read latency is configurable, and requests and responses use a valid/ready handshake. Misaligned, out-of-range and illegal-size accesses are reported as faults instead of being silently dropped. Register-file sideband signals travel with each request and come back aligned with its response.

## Interface
Parameters:
- XLEN, 64, data/address width; legal values 32 or 64.
- DEPTH_WORDS, 1024, memory depth in XLEN-bit words; power of two.
- READ_LATENCY, 1, edges from request acceptance to response; legal range 1..4.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  XLEN  byte address (the ALU result).
- req_wdata  in  XLEN  store data; valid bytes are right-aligned.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword.
- req_unsigned  in  1  zero-extend the load when set; sign-extend otherwise.
- req_rd  in  5  destination register, passed through.
- req_regwrite  in  1  passed through.
- req_memtoreg  in  1  passed through.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  XLEN  extended load data; 0 for stores and faults.
- resp_fault  out  2  fault cause: 00 none, 01 misaligned, 10 out of range, 11 illegal size.
- resp_rd, resp_regwrite, resp_memtoreg  out  5/1/1  sideband of the request this response belongs to; resp_regwrite is forced to 0 on a fault.

## Operation
- FSM states: IDLE, WAIT, RESP. At most one request is in flight.
- IDLE: req_ready = 1. An accepted request (req_valid & req_ready) moves to WAIT with cnt = READ_LATENCY-1, or straight to RESP if READ_LATENCY = 1.
- WAIT: cnt decrements each edge. Moves to RESP when cnt = 0 at an edge.
- RESP: resp_valid = 1 and outputs are held stable. The resp_valid & resp_ready edge returns to IDLE.
- Word index = req_addr[log2(DEPTH_WORDS)+log2(XLEN/8)-1 : log2(XLEN/8)]. Byte lane = the low log2(XLEN/8) address bits.
- Fault checks are evaluated at acceptance, highest priority first:
  - illegal size: size = 3 with XLEN = 32;
  - misaligned: the low size address bits are not zero;
  - out of range: req_addr ≥ DEPTH_WORDS·XLEN/8.
- Store: written on the acceptance edge using byte enables for the addressed lanes; other lanes are untouched. A faulting store writes nothing. The store still returns a response with rdata 0.
- Load: the word is captured on the acceptance edge. The selected lanes are shifted down and sign- or zero-extended to XLEN. A faulting load returns 0.
- Memory array is not reset and its contents are not initialised by this unit.

## Timing
- Reset (asynchronous): state IDLE, cnt 0, resp_valid 0, resp_rdata 0, resp_fault 00, resp_rd 0, resp_regwrite 0, resp_memtoreg 0. req_ready becomes 1 once reset is released.
- Latency: a request accepted at edge E gives resp_valid = 1 in the cycle after edge E+READ_LATENCY-1.
- Throughput with resp_ready tied high: one operation every READ_LATENCY+1 cycles.
- req_ready = 0 in WAIT and RESP. Requests presented then are ignored and must be held by the producer.
- Reset asserted mid-operation: the pending response is dropped. A store whose acceptance edge already occurred stays committed.
- Store followed by a load to the same address: the load sees the new data, because operations are serialised.
- Addresses above the range never wrap onto low memory; they fault instead.

## Test plan
- Reset, XLEN = 64, READ_LATENCY = 1: store dword 0x1122334455667788 at 0x10, then load dword at 0x10 → rdata 0x1122334455667788, fault 00, resp_valid exactly 1 cycle after acceptance.
- Store byte 0x80 at 0x13, then load byte signed at 0x13 → 0xFFFFFFFFFFFFFF80; unsigned → 0x80. Load dword at 0x10 → 0x1122334480667788.
- Load half at 0x11 → fault 01, rdata 0, resp_regwrite 0. Store word at 0x2000 → fault 10 and memory unchanged.
- READ_LATENCY = 3, resp_ready held low 2 cycles → resp_valid first high 3 cycles after acceptance, outputs stable while stalled, req_ready stays 0 until the response handshake; a second req_valid during the stall is not accepted.
- Assert reset while in WAIT → resp_valid 0 and req_ready 1 after release, with no spurious response. XLEN = 32 with size 3 → fault 11.
